// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory macro.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [1:0]      gnt_id;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch, load/store and loader ports.
// Each transaction runs IDLE (arbitrate) -> ACCESS (LATENCY cycles) -> RESP (ack pulse).
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned LATENCY = 1
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_gnt_id;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic [1:0]      w_c1;
  logic [1:0]      w_c2;
  logic [1:0]      w_c3;
  logic            w_found;
  logic [1:0]      w_pick;
  logic            w_last_beat;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Scan order starts one past the previous winner so no port waits more than two transactions.
  assign w_c1 = next_port(r_last);
  assign w_c2 = next_port(w_c1);
  assign w_c3 = next_port(w_c2);

  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    if (bus.req[w_c1]) begin
      w_found = 1'b1;
      w_pick  = w_c1;
    end else if (bus.req[w_c2]) begin
      w_found = 1'b1;
      w_pick  = w_c2;
    end else if (bus.req[w_c3]) begin
      w_found = 1'b1;
      w_pick  = w_c3;
    end
  end

  assign w_last_beat = (r_cnt == CW'(LATENCY - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_last   <= 2'd2;
      r_gnt_id <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last   <= w_pick;
            r_gnt_id <= w_pick;
            r_we     <= bus.we[w_pick];
            r_addr   <= bus.addr[w_pick*AW +: AW];
            r_wdata  <= bus.wdata[w_pick*DW +: DW];
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last_beat) begin
            if (!r_we) begin
              r_rdata <= bus.mem_rdata;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory strobes and ack decode straight from state so reset kills them without waiting for a clock.
  assign bus.mem_en    = (r_state == S_ACCESS);
  assign bus.mem_we    = (r_state == S_ACCESS) && r_we && (r_cnt == '0);
  assign bus.mem_addr  = (r_state == S_ACCESS) ? r_addr  : '0;
  assign bus.mem_wdata = (r_state == S_ACCESS) ? r_wdata : '0;
  assign bus.ack       = (r_state == S_RESP) ? (3'b001 << r_gnt_id) : 3'b000;

  assign bus.rdata  = r_rdata;
  assign bus.busy   = r_busy;
  assign bus.gnt_id = r_gnt_id;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one LATENCY=1 instance and one LATENCY=3 instance,
// each with its own behavioural memory.
module tb_mem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst1_n;
  logic rst3_n;

  mem_arbiter_if b1 ();
  mem_arbiter_if b3 ();

  mem_arbiter #(.AW(16), .DW(16), .LATENCY(1)) u_dut1 (.clock(clock), .reset(rst1_n), .bus(b1));
  mem_arbiter #(.AW(16), .DW(16), .LATENCY(3)) u_dut3 (.clock(clock), .reset(rst3_n), .bus(b3));

  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic        pl_en;
  int          pl_sel;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clock) begin
    if (pl_en && pl_sel == 1) mem1[pl_addr] <= pl_data;
    else if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
  end
  always @(posedge clock) begin
    if (pl_en && pl_sel == 3) mem3[pl_addr] <= pl_data;
    else if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
  end
  assign b1.mem_rdata = mem1[b1.mem_addr];
  assign b3.mem_rdata = mem3[b3.mem_addr];

  typedef struct {
    int          port;
    logic [15:0] rdata;
  } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int ack_port(input logic [2:0] a);
    if (a[0]) return 0;
    if (a[1]) return 1;
    if (a[2]) return 2;
    return -1;
  endfunction

  task automatic preload(input int sel, input logic [15:0] a, input logic [15:0] d);
    @(posedge clock); #1;
    pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input int sel, input int port, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
    if (sel == 1) begin
      b1.req[port] = 1'b1; b1.we[port] = w;
      b1.addr[port*16 +: 16] = a; b1.wdata[port*16 +: 16] = d;
    end else begin
      b3.req[port] = 1'b1; b3.we[port] = w;
      b3.addr[port*16 +: 16] = a; b3.wdata[port*16 +: 16] = d;
    end
  endtask

  task automatic drop_req(input int sel, input int port);
    if (sel == 1) begin
      b1.req[port] = 1'b0; b1.we[port] = 1'b0;
    end else begin
      b3.req[port] = 1'b0; b3.we[port] = 1'b0;
    end
  endtask

  task automatic sample(input int sel, output logic en, output logic we, output logic [2:0] ak,
                        output logic [15:0] rd, output logic busy, output logic [1:0] gid);
    if (sel == 1) begin
      en = b1.mem_en; we = b1.mem_we; ak = b1.ack; rd = b1.rdata; busy = b1.busy; gid = b1.gnt_id;
    end else begin
      en = b3.mem_en; we = b3.mem_we; ak = b3.ack; rd = b3.rdata; busy = b3.busy; gid = b3.gnt_id;
    end
  endtask

  // Single transaction: cycle 1 is the arbitration cycle, observations taken on falling edges.
  task automatic run_txn(input int sel, input int port, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output int ack_cyc, output int en_cyc,
                         output int we_cyc, output int busy_cyc, output logic [2:0] ack_v,
                         output logic [15:0] rd, output logic [1:0] gid);
    logic en, we_s, busy;
    logic [2:0] ak;
    logic [15:0] r;
    logic [1:0] g;
    ack_cyc = -1; en_cyc = 0; we_cyc = 0; busy_cyc = 0;
    ack_v = 3'b000; rd = 16'h0; gid = 2'd0;
    @(posedge clock); #1;
    drive_req(sel, port, w, a, d);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      sample(sel, en, we_s, ak, r, busy, g);
      if (en) en_cyc++;
      if (we_s) we_cyc++;
      if (busy) busy_cyc++;
      if (ak != 3'b000) begin
        ack_cyc = c; ack_v = ak; rd = r; gid = g;
        break;
      end
    end
    @(posedge clock); #1;
    drop_req(sel, port);
  endtask

  task automatic test_reset();
    rst1_n = 1'b0; rst3_n = 1'b0; pl_en = 1'b0; pl_sel = 0; pl_addr = '0; pl_data = '0;
    b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0;
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({b1.ack, b1.mem_en, b1.mem_we, b1.busy, b1.gnt_id} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctl1: got %b want 0", {b1.ack, b1.mem_en, b1.mem_we, b1.busy, b1.gnt_id});
    end
    n_tests++;
    if ({b1.rdata, b1.mem_addr, b1.mem_wdata} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data1: got %h want 0", {b1.rdata, b1.mem_addr, b1.mem_wdata});
    end
    n_tests++;
    if ({b3.ack, b3.mem_en, b3.mem_we, b3.busy, b3.gnt_id, b3.rdata} !== 24'h0) begin
      n_fail++; $display("FAIL reset_all3: got %h want 0", {b3.ack, b3.mem_en, b3.mem_we, b3.busy, b3.gnt_id, b3.rdata});
    end
    @(posedge clock); #1;
    rst1_n = 1'b1; rst3_n = 1'b1;
  endtask

  task automatic test_single_read();
    int ac, ec, wc, bc;
    logic [2:0] av;
    logic [15:0] rd;
    logic [1:0] gid;
    exp_t e;
    preload(1, 16'h0040, 16'hBEEF);
    sbq.push_back('{0, 16'hBEEF});
    run_txn(1, 0, 1'b0, 16'h0040, 16'h0000, ac, ec, wc, bc, av, rd, gid);
    e = sbq.pop_front();
    n_tests++;
    if (ac !== 3) begin n_fail++; $display("FAIL rd1_ack_cycle: got %0d want 3", ac); end
    n_tests++;
    if (ec !== 1 || wc !== 0 || bc !== 2) begin
      n_fail++; $display("FAIL rd1_en_we_busy: got en=%0d we=%0d busy=%0d want 1 0 2", ec, wc, bc);
    end
    n_tests++;
    if (av !== (3'b001 << e.port) || rd !== e.rdata || gid !== 2'(e.port)) begin
      n_fail++; $display("FAIL rd1_ack_data: got ack=%b rdata=%h gnt=%0d want ack=%b rdata=%h gnt=%0d",
                         av, rd, gid, 3'b001 << e.port, e.rdata, e.port);
    end
    @(negedge clock);
    n_tests++;
    if (b1.busy !== 1'b0 || b1.mem_en !== 1'b0 || b1.ack !== 3'b000) begin
      n_fail++; $display("FAIL rd1_no_regrant: got busy=%b en=%b ack=%b want 0 0 000", b1.busy, b1.mem_en, b1.ack);
    end
  endtask

  task automatic test_write_read();
    int ac, ec, wc, bc;
    logic [2:0] av;
    logic [15:0] rd;
    logic [1:0] gid;
    exp_t e;
    sbq.push_back('{1, 16'hBEEF});
    run_txn(1, 1, 1'b1, 16'h0100, 16'h1234, ac, ec, wc, bc, av, rd, gid);
    e = sbq.pop_front();
    n_tests++;
    if (ac !== 3 || wc !== 1 || ec !== 1) begin
      n_fail++; $display("FAIL wr_timing: got ack_cyc=%0d we=%0d en=%0d want 3 1 1", ac, wc, ec);
    end
    n_tests++;
    if (av !== (3'b001 << e.port) || rd !== e.rdata) begin
      n_fail++; $display("FAIL wr_ack_hold: got ack=%b rdata=%h want ack=%b rdata=%h", av, rd, 3'b001 << e.port, e.rdata);
    end
    n_tests++;
    if (mem1[16'h0100] !== 16'h1234) begin
      n_fail++; $display("FAIL wr_mem: got %h want 1234", mem1[16'h0100]);
    end
    sbq.push_back('{1, 16'h1234});
    run_txn(1, 1, 1'b0, 16'h0100, 16'h0000, ac, ec, wc, bc, av, rd, gid);
    e = sbq.pop_front();
    n_tests++;
    if (ac !== 3 || wc !== 0 || av !== (3'b001 << e.port) || rd !== e.rdata) begin
      n_fail++; $display("FAIL rd_after_wr: got cyc=%0d we=%0d ack=%b rdata=%h want 3 0 %b %h",
                         ac, wc, av, rd, 3'b001 << e.port, e.rdata);
    end
  endtask

  task automatic test_contention();
    int got = 0, prev = -1, drop_p = -1, raise_p = -1, p;
    exp_t e;
    for (int i = 0; i < 3; i++) preload(1, 16'(16'h0010 + i), 16'(16'hA000 + i));
    @(posedge clock); #1;
    rst1_n = 1'b0;
    b1.we = 3'b000;
    b1.addr = {16'h0012, 16'h0011, 16'h0010};
    b1.req = 3'b111;
    @(posedge clock); #1;
    rst1_n = 1'b1;
    for (int k = 0; k < 6; k++) sbq.push_back('{k % 3, 16'(16'hA000 + (k % 3))});
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(posedge clock); #1;
      if (raise_p >= 0) begin b1.req[raise_p] = 1'b1; raise_p = -1; end
      if (drop_p >= 0) begin b1.req[drop_p] = 1'b0; raise_p = drop_p; drop_p = -1; end
      @(negedge clock);
      if (b1.ack != 3'b000) begin
        e = sbq.pop_front();
        p = ack_port(b1.ack);
        n_tests++;
        if (b1.ack !== (3'b001 << e.port) || b1.rdata !== e.rdata) begin
          n_fail++; $display("FAIL cont_order[%0d]: got ack=%b rdata=%h want ack=%b rdata=%h",
                             got, b1.ack, b1.rdata, 3'b001 << e.port, e.rdata);
        end
        if (prev >= 0) begin
          n_tests++;
          if (c - prev !== 3) begin
            n_fail++; $display("FAIL cont_spacing[%0d]: got %0d want 3", got, c - prev);
          end
        end
        prev = c; drop_p = p; got++;
      end
    end
    n_tests++;
    if (got !== 6) begin n_fail++; $display("FAIL cont_count: got %0d acks want 6", got); end
    sbq.delete();
    @(posedge clock); #1;
    b1.req = 3'b000;
  endtask

  task automatic test_fairness();
    int got = 0, drop_p = -1;
    logic saw2 = 1'b0;
    exp_t e;
    sbq.push_back('{0, 16'hA000});
    sbq.push_back('{2, 16'hA002});
    sbq.push_back('{0, 16'hA000});
    @(posedge clock); #1;
    drive_req(1, 0, 1'b0, 16'h0010, 16'h0);
    drive_req(1, 2, 1'b0, 16'h0012, 16'h0);
    for (int c = 0; c < 40 && got < 3; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        if (drop_p >= 0) begin drop_req(1, drop_p); drop_p = -1; end
      end
      @(negedge clock);
      if (b1.busy && b1.gnt_id == 2'd2) saw2 = 1'b1;
      if (b1.ack != 3'b000) begin
        e = sbq.pop_front();
        n_tests++;
        if (b1.ack !== (3'b001 << e.port) || b1.rdata !== e.rdata) begin
          n_fail++; $display("FAIL fair_order[%0d]: got ack=%b rdata=%h want ack=%b rdata=%h",
                             got, b1.ack, b1.rdata, 3'b001 << e.port, e.rdata);
        end
        if (ack_port(b1.ack) == 2) drop_p = 2;
        got++;
      end
    end
    n_tests++;
    if (got !== 3 || saw2 !== 1'b1) begin
      n_fail++; $display("FAIL fair_port2: got acks=%0d saw_gnt2=%b want 3 1", got, saw2);
    end
    sbq.delete();
    @(posedge clock); #1;
    b1.req = 3'b000;
  endtask

  task automatic test_latency3();
    int ac, ec, wc, bc;
    logic [2:0] av;
    logic [15:0] rd;
    logic [1:0] gid;
    exp_t e;
    preload(3, 16'h0007, 16'h00A5);
    sbq.push_back('{0, 16'h00A5});
    run_txn(3, 0, 1'b0, 16'h0007, 16'h0000, ac, ec, wc, bc, av, rd, gid);
    e = sbq.pop_front();
    n_tests++;
    if (ac !== 5 || ec !== 3 || wc !== 0 || bc !== 4) begin
      n_fail++; $display("FAIL lat3_timing: got ack_cyc=%0d en=%0d we=%0d busy=%0d want 5 3 0 4", ac, ec, wc, bc);
    end
    n_tests++;
    if (av !== (3'b001 << e.port) || rd !== e.rdata || gid !== 2'(e.port)) begin
      n_fail++; $display("FAIL lat3_data: got ack=%b rdata=%h gnt=%0d want %b %h %0d",
                         av, rd, gid, 3'b001 << e.port, e.rdata, e.port);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0, drop_p = -1;
    exp_t e;
    preload(3, 16'h0020, 16'h0000);
    preload(3, 16'h0008, 16'h00C3);
    // Abort a write while its strobe is high.
    @(posedge clock); #1;
    drive_req(3, 1, 1'b1, 16'h0020, 16'h5555);
    repeat (2) @(negedge clock);
    n_tests++;
    if (b3.mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we: got %b want 1", b3.mem_we); end
    rst3_n = 1'b0;
    #1;
    n_tests++;
    if ({b3.mem_en, b3.mem_we, b3.busy, b3.ack} !== 6'b0) begin
      n_fail++; $display("FAIL rst_wr_abort: got en=%b we=%b busy=%b ack=%b want 0", b3.mem_en, b3.mem_we, b3.busy, b3.ack);
    end
    @(posedge clock); #1;
    drop_req(3, 1);
    @(negedge clock);
    n_tests++;
    if (mem3[16'h0020] !== 16'h0000 || b3.ack !== 3'b000) begin
      n_fail++; $display("FAIL rst_wr_nowrite: got mem=%h ack=%b want 0000 000", mem3[16'h0020], b3.ack);
    end
    @(posedge clock); #1;
    rst3_n = 1'b1;
    // Abort a read at cnt==1, then check arbitration restarts from port 0.
    @(posedge clock); #1;
    drive_req(3, 0, 1'b0, 16'h0007, 16'h0);
    drive_req(3, 2, 1'b0, 16'h0008, 16'h0);
    repeat (3) @(negedge clock);
    n_tests++;
    if (b3.mem_en !== 1'b1 || b3.gnt_id !== 2'd0) begin
      n_fail++; $display("FAIL rst_pre_rd: got en=%b gnt=%0d want 1 0", b3.mem_en, b3.gnt_id);
    end
    rst3_n = 1'b0;
    #1;
    n_tests++;
    if ({b3.mem_en, b3.mem_we, b3.busy, b3.ack} !== 6'b0) begin
      n_fail++; $display("FAIL rst_rd_abort: got en=%b we=%b busy=%b ack=%b want 0", b3.mem_en, b3.mem_we, b3.busy, b3.ack);
    end
    @(negedge clock);
    n_tests++;
    if (b3.ack !== 3'b000) begin n_fail++; $display("FAIL rst_rd_noack: got %b want 000", b3.ack); end
    @(posedge clock); #1;
    rst3_n = 1'b1;
    sbq.push_back('{0, 16'h00A5});
    sbq.push_back('{2, 16'h00C3});
    for (int c = 0; c < 40 && got < 2; c++) begin
      @(posedge clock); #1;
      if (drop_p >= 0) begin drop_req(3, drop_p); drop_p = -1; end
      @(negedge clock);
      if (b3.ack != 3'b000) begin
        e = sbq.pop_front();
        n_tests++;
        if (b3.ack !== (3'b001 << e.port) || b3.rdata !== e.rdata) begin
          n_fail++; $display("FAIL rst_regrant[%0d]: got ack=%b rdata=%h want ack=%b rdata=%h",
                             got, b3.ack, b3.rdata, 3'b001 << e.port, e.rdata);
        end
        drop_p = ack_port(b3.ack);
        got++;
      end
    end
    n_tests++;
    if (got !== 2) begin n_fail++; $display("FAIL rst_regrant_count: got %0d want 2", got); end
    sbq.delete();
    @(posedge clock); #1;
    b3.req = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_fairness();
    test_latency3();
    test_reset_mid();
    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified 16-bit memory between three requesters: instruction fetch (port 0), data load/store (port 1), and program loader/debug (port 2).
- Sits between ProcessorSansControl's memory interface and the memory macro.
- Uses round-robin arbitration, a fixed-latency access sequencer and a per-port req/ack handshake.
- Allows the multi-cycle datapath and the loader to coexist without bus contention.

Parameters:
AW, 16, address width
DW, 16, data width
LATENCY, 1, memory access cycles per transaction (>=1); mem_rdata valid during the last ACCESS cycle

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  3  request per port, bit i = port i
we  in  3  write enable per port, qualifies req
addr  in  3*AW  packed addresses, port i at [i*AW +: AW]
wdata  in  3*DW  packed write data, port i at [i*DW +: DW]
ack  out  3  one-cycle completion pulse per port
rdata  out  DW  read data, shared by all ports, valid when any ack bit is high
mem_en  out  1  memory enable
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  transaction in progress (ACCESS or RESP)
gnt_id  out  2  port currently granted (0..2)

Behaviour:
- Reset (reset low, asynchronous) drives the following:
  - state=IDLE, last=2 (port 0 wins first), cnt=0.
  - ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, gnt_id=0.
- Handshake:
  - A requester holds req[i], we[i], addr and wdata stable until it sees ack[i]=1.
  - It drops req[i] at the edge ending the ack cycle.
  - Each transaction produces exactly one ack pulse.
- State machine:
  - IDLE:
    - If req==0, remain in IDLE.
    - Otherwise grant the first asserted port scanning (last+1), (last+2), (last+3) mod 3.
    - Latch id, we, addr and wdata; set last=id, gnt_id=id, cnt=0; go to ACCESS.
  - ACCESS:
    - mem_en=1; mem_addr and mem_wdata come from the latched values.
    - mem_we=latched we only when cnt==0 (one-cycle write strobe).
    - cnt increments each cycle.
    - When cnt==LATENCY-1: capture mem_rdata into rdata if the transaction is a read (rdata holds its previous value on writes), then go to RESP.
  - RESP:
    - ack[id]=1 and mem_en=0; go to IDLE.
- Timing: every transaction occupies 1 (IDLE arbitrate) + LATENCY + 1 (RESP) cycles. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- busy=1 in ACCESS and RESP. gnt_id is held from grant until the next grant.
- The RESP→IDLE transition ensures a requester dropping req after ack is never re-granted spuriously.
- Boundary conditions:
  - Simultaneous requests: resolved strictly round-robin; no port waits more than 2 transactions.
  - req[i] withdrawn during ACCESS: the transaction still completes and acks (tolerated protocol violation).
  - Requests arriving during ACCESS/RESP: queued implicitly by the held req and arbitrated at the next IDLE.
  - Reset mid-transaction: aborts immediately with no ack; the memory write strobe is dropped asynchronously.
  - Only ack and the mem_* signals are combinational from state. All other outputs are registered.

Test Plan:
- Single read, LATENCY=1: preload mem[0x0040]=0xBEEF; pulse req=001, addr0=0x0040 → mem_en high for 1 cycle, ack=001 on cycle 3, rdata=0xBEEF.
- Write then read: port1 writes 0x1234 to 0x0100, then reads 0x0100 → mem_we high for exactly 1 cycle; the read ack carries rdata=0x1234.
- Contention: req=111 held from reset, each port dropping req after its ack then re-raising it → grant order 0,1,2,0,1,2; ack spacing 3 cycles.
- Fairness: port0 holds req continuously, port2 raises req once → port2 is granted within 2 transactions; gnt_id=2 is observed.
- LATENCY=3: read 0x0007 holding 0x00A5 → ack 5 cycles after the grant cycle starts; mem_en high for 3 cycles; mem_we stays 0.
- Reset mid-ACCESS (LATENCY=3): assert reset low at cnt==1 → mem_en and mem_we drop to 0 immediately, no ack, busy=0. After reset release, port0 is the first grant.
